// File: rtl/snn_teacher_scorer.sv
// Teacher-spike generator and winner-take-all scorer for the SNN output layer.
// Drives periodic teacher spikes into the labelled neuron and scores each pattern window.
module snn_teacher_scorer #(
  parameter int P_NEURONS      = 8,
  parameter int P_LABEL_W      = 3,
  parameter int P_WINDOW       = 100,
  parameter int P_TEACH_PERIOD = 5,
  parameter int P_CNT_W        = 8,
  parameter int P_SCORE_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pattern_start,
  input  logic [P_LABEL_W-1:0] i_label,
  input  logic                 i_end_of_epochs,
  input  logic [P_NEURONS-1:0] i_neuron_spike,
  output logic [P_NEURONS-1:0] o_teacher_spike,
  output logic                 o_window_active,
  output logic                 o_result_valid,
  output logic [P_LABEL_W-1:0] o_winner,
  output logic                 o_correct,
  output logic                 o_no_fire,
  output logic [P_SCORE_W-1:0] o_pattern_count,
  output logic [P_SCORE_W-1:0] o_correct_count,
  output logic                 o_frozen,
  output logic                 o_overrun
);

  // Sized so that wc + 1 on the last window cycle never wraps.
  localparam int WC_W = $clog2(P_WINDOW + 1);
  localparam logic [WC_W-1:0]      WC_ONE    = {{(WC_W-1){1'b0}}, 1'b1};
  localparam logic [P_CNT_W-1:0]   CNT_ONE   = {{(P_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [P_CNT_W-1:0]   CNT_MAX   = {P_CNT_W{1'b1}};
  localparam logic [P_SCORE_W-1:0] SCORE_ONE = {{(P_SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [P_SCORE_W-1:0] SCORE_MAX = {P_SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [WC_W-1:0]        wc_r;
  logic [P_LABEL_W-1:0]   label_r;
  logic [P_CNT_W-1:0]     cnt_r [P_NEURONS];

  logic                   wc_last_s, label_ok_s, teach_slot_s, freeze_s, busy_s;
  logic                   fired_s, correct_s;
  logic [P_LABEL_W-1:0]   best_idx_s;
  logic [P_CNT_W-1:0]     best_cnt_s;

  assign o_window_active = (state_r == ST_WINDOW);

  // Window bookkeeping flags derived from the current state and window counter.
  always_comb begin
    wc_last_s    = (int'(wc_r) == (P_WINDOW - 32'sd1));
    label_ok_s   = (int'(label_r) < P_NEURONS);
    teach_slot_s = (state_r == ST_WINDOW) && ((int'(wc_r) % P_TEACH_PERIOD) == 32'sd0);
    freeze_s     = i_end_of_epochs && !o_frozen;
    busy_s       = (state_r == ST_WINDOW) || (state_r == ST_DECIDE);
  end

  // Argmax over the spike counters; strict compare keeps ties on the lowest index.
  always_comb begin
    best_idx_s = {P_LABEL_W{1'b0}};
    best_cnt_s = cnt_r[0];
    fired_s    = 1'b0;
    for (int n = 0; n < P_NEURONS; n++) begin
      best_idx_s = (cnt_r[n] > best_cnt_s) ? P_LABEL_W'(n) : best_idx_s;
      best_cnt_s = (cnt_r[n] > best_cnt_s) ? cnt_r[n] : best_cnt_s;
      fired_s    = fired_s | (cnt_r[n] != {P_CNT_W{1'b0}});
    end
    correct_s = fired_s && label_ok_s && (best_idx_s == label_r);
  end

  // Teacher spike: one-hot of the latched label on every teaching slot while not frozen.
  always_comb begin
    o_teacher_spike = {P_NEURONS{1'b0}};
    if (teach_slot_s && !o_frozen && label_ok_s) begin
      for (int n = 0; n < P_NEURONS; n++) begin
        o_teacher_spike[n] = (int'(label_r) == n);
      end
    end else begin
      o_teacher_spike = {P_NEURONS{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_pattern_start) begin
          state_nxt_s = ST_WINDOW;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WINDOW: begin
        if (wc_last_s) begin
          state_nxt_s = ST_DECIDE;
        end else begin
          state_nxt_s = ST_WINDOW;
        end
      end
      ST_DECIDE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Window counter, label latch and saturating per-neuron spike counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wc_r    <= {WC_W{1'b0}};
      label_r <= {P_LABEL_W{1'b0}};
      for (int n = 0; n < P_NEURONS; n++) cnt_r[n] <= {P_CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && i_pattern_start) begin
      wc_r    <= {WC_W{1'b0}};
      label_r <= i_label;
      for (int n = 0; n < P_NEURONS; n++) cnt_r[n] <= {P_CNT_W{1'b0}};
    end else if (state_r == ST_WINDOW) begin
      wc_r <= wc_r + WC_ONE;
      for (int n = 0; n < P_NEURONS; n++) begin
        if (i_neuron_spike[n] && (cnt_r[n] != CNT_MAX)) cnt_r[n] <= cnt_r[n] + CNT_ONE;
      end
    end
  end

  // Result registers, score counters and sticky status; a freeze clear beats a same-edge result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_result_valid  <= 1'b0;
      o_winner        <= {P_LABEL_W{1'b0}};
      o_correct       <= 1'b0;
      o_no_fire       <= 1'b0;
      o_pattern_count <= {P_SCORE_W{1'b0}};
      o_correct_count <= {P_SCORE_W{1'b0}};
      o_frozen        <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      o_result_valid <= (state_r == ST_DECIDE);
      if (state_r == ST_DECIDE) begin
        o_winner  <= best_idx_s;
        o_correct <= correct_s;
        o_no_fire <= !fired_s;
      end
      if (busy_s && i_pattern_start) o_overrun <= 1'b1;
      if (freeze_s) begin
        o_frozen        <= 1'b1;
        o_pattern_count <= {P_SCORE_W{1'b0}};
        o_correct_count <= {P_SCORE_W{1'b0}};
      end else if (state_r == ST_DECIDE) begin
        if (o_pattern_count != SCORE_MAX) o_pattern_count <= o_pattern_count + SCORE_ONE;
        if (correct_s && (o_correct_count != SCORE_MAX)) o_correct_count <= o_correct_count + SCORE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_snn_teacher_scorer.sv
// Bench for snn_teacher_scorer: table-driven pattern scoring, hand-built timing corners,
// and random traffic checked every cycle against a window-timeline reference model.
module tb_snn_teacher_scorer;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_pattern_start = 1'b0;
  logic [2:0] i_label = 3'd0;
  logic       i_end_of_epochs = 1'b0;
  logic [7:0] i_neuron_spike = 8'h00;
  logic [7:0] o_teacher_spike;
  logic       o_window_active, o_result_valid, o_correct, o_no_fire, o_frozen, o_overrun;
  logic [2:0] o_winner;
  logic [15:0] o_pattern_count, o_correct_count;

  snn_teacher_scorer #(
    .P_NEURONS(8), .P_LABEL_W(3), .P_WINDOW(20), .P_TEACH_PERIOD(5), .P_CNT_W(8), .P_SCORE_W(16)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pattern_start(i_pattern_start), .i_label(i_label),
    .i_end_of_epochs(i_end_of_epochs), .i_neuron_spike(i_neuron_spike),
    .o_teacher_spike(o_teacher_spike), .o_window_active(o_window_active),
    .o_result_valid(o_result_valid), .o_winner(o_winner), .o_correct(o_correct),
    .o_no_fire(o_no_fire), .o_pattern_count(o_pattern_count), .o_correct_count(o_correct_count),
    .o_frozen(o_frozen), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rst_lvl = 1'b0;
  logic eoe_lvl = 1'b0;
  logic [7:0] hist[$];

  // Reference model: a window is described by its first cycle; everything else is cycle arithmetic.
  bit m_have, m_frozen, m_overrun, m_correct, m_nofire;
  int m_ws, m_label, m_rv, m_winner, m_pc, m_cc;

  function automatic void m_reset();
    m_have = 1'b0; m_frozen = 1'b0; m_overrun = 1'b0; m_correct = 1'b0; m_nofire = 1'b0;
    m_ws = 0; m_label = 0; m_rv = -1; m_winner = 0; m_pc = 0; m_cc = 0;
  endfunction

  function automatic bit m_in_win(int c);
    return m_have && (c >= m_ws) && (c <= m_ws + 19);
  endfunction

  function automatic void m_update(logic rst_n_v, logic st, int lab, logic eoe);
    bit freeze, busy, any;
    int cnt[8];
    int best;
    if (!rst_n_v) begin
      m_reset();
      return;
    end
    freeze = eoe && !m_frozen;
    busy   = m_have && (cyc >= m_ws) && (cyc <= m_ws + 20);
    if (m_have && (cyc == m_ws + 20)) begin
      for (int n = 0; n < 8; n++) cnt[n] = 0;
      for (int c = m_ws; c <= m_ws + 19; c++)
        for (int n = 0; n < 8; n++) cnt[n] += int'(hist[c][n]);
      best = 0;
      any = 1'b0;
      for (int n = 0; n < 8; n++) begin
        if (cnt[n] > cnt[best]) best = n;
        if (cnt[n] > 0) any = 1'b1;
      end
      m_winner  = best;
      m_nofire  = !any;
      m_correct = any && (best == m_label);
      m_rv      = cyc + 1;
      if (!freeze) begin
        if (m_pc < 65535) m_pc++;
        if (m_correct && m_cc < 65535) m_cc++;
      end
    end
    if (st) begin
      if (busy) m_overrun = 1'b1;
      else begin
        m_label = lab;
        m_ws    = cyc + 1;
        m_have  = 1'b1;
      end
    end
    if (freeze) begin
      m_frozen = 1'b1;
      m_pc = 0;
      m_cc = 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0] t;
    t = (m_in_win(cyc) && !m_frozen && (((cyc - m_ws) % 5) == 0)) ? (32'd1 << m_label) : 32'd0;
    chk("teacher", 32'(o_teacher_spike), t);
    chk("window_active", 32'(o_window_active), 32'(m_in_win(cyc)));
    chk("result_valid", 32'(o_result_valid), 32'(cyc == m_rv));
    chk("winner", 32'(o_winner), m_winner);
    chk("correct", 32'(o_correct), 32'(m_correct));
    chk("no_fire", 32'(o_no_fire), 32'(m_nofire));
    chk("pattern_count", 32'(o_pattern_count), m_pc);
    chk("correct_count", 32'(o_correct_count), m_cc);
    chk("frozen", 32'(o_frozen), 32'(m_frozen));
    chk("overrun", 32'(o_overrun), 32'(m_overrun));
  endtask

  task automatic step(input logic st, input logic [2:0] lab, input logic [7:0] sp);
    i_rst_n = rst_lvl; i_pattern_start = st; i_label = lab;
    i_end_of_epochs = eoe_lvl; i_neuron_spike = sp;
    hist.push_back(sp);
    m_update(rst_lvl, st, int'(lab), eoe_lvl);
    @(posedge i_clk);
    #1;
    cyc++;
    model_check();
  endtask

  typedef struct packed {
    logic [2:0]      label;
    logic [7:0][4:0] cnt;
    logic [2:0]      win;
    logic            corr;
    logic            nf;
    logic [15:0]     pc;
    logic [15:0]     cc;
  } vec_t;

  function automatic vec_t mk(logic [2:0] l, logic [7:0][4:0] c, logic [2:0] w,
                              logic co, logic nf, logic [15:0] pc, logic [15:0] cc);
    vec_t v;
    v.label = l; v.cnt = c; v.win = w; v.corr = co; v.nf = nf; v.pc = pc; v.cc = cc;
    return v;
  endfunction

  // Start pulse, 20 window cycles (neuron n spikes in its first cnt[n] cycles), decide; ends on result cycle.
  task automatic run_pattern(input logic [2:0] lab, input logic [7:0][4:0] c);
    logic [7:0] sp;
    step(1'b1, lab, 8'h00);
    for (int k = 0; k < 20; k++) begin
      for (int n = 0; n < 8; n++) sp[n] = (k < int'(c[n]));
      step(1'b0, 3'd0, sp);
    end
    step(1'b0, 3'd0, 8'h00);
  endtask

  vec_t tv [6];
  int rv_seen;

  initial begin
    // counts listed neuron 7 .. neuron 0
    tv[0] = mk(3'd3, {5'd0, 5'd0, 5'd2, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0},  3'd3, 1'b1, 1'b0, 16'd1, 16'd1);
    tv[1] = mk(3'd6, {5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0},  3'd2, 1'b0, 1'b0, 16'd2, 16'd1);
    tv[2] = mk(3'd0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},  3'd0, 1'b0, 1'b1, 16'd3, 16'd1);
    tv[3] = mk(3'd7, {5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd19}, 3'd7, 1'b1, 1'b0, 16'd4, 16'd2);
    tv[4] = mk(3'd0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1},  3'd0, 1'b1, 1'b0, 16'd5, 16'd3);
    tv[5] = mk(3'd5, {5'd0, 5'd0, 5'd4, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0},  3'd1, 1'b0, 1'b0, 16'd6, 16'd3);

    m_reset();
    rst_lvl = 1'b0;
    repeat (3) step(1'b0, 3'd0, 8'h00);
    rst_lvl = 1'b1;
    step(1'b0, 3'd0, 8'h00);
    chk("reset_pcount", 32'(o_pattern_count), 32'd0);
    chk("reset_frozen", 32'(o_frozen), 32'd0);
    chk("reset_teacher", 32'(o_teacher_spike), 32'd0);

    // Table: one pattern per row, back-to-back (each start lands in the previous result cycle).
    for (int i = 0; i < 6; i++) begin
      run_pattern(tv[i].label, tv[i].cnt);
      chk("tbl_result_valid", 32'(o_result_valid), 32'd1);
      chk("tbl_winner", 32'(o_winner), 32'(tv[i].win));
      chk("tbl_correct", 32'(o_correct), 32'(tv[i].corr));
      chk("tbl_no_fire", 32'(o_no_fire), 32'(tv[i].nf));
      chk("tbl_pcount", 32'(o_pattern_count), 32'(tv[i].pc));
      chk("tbl_ccount", 32'(o_correct_count), 32'(tv[i].cc));
    end
    step(1'b0, 3'd0, 8'h00);

    // Overrun: start at T+10 ignored; start in T+22 result cycle accepted.
    step(1'b1, 3'd1, 8'h00);
    for (int k = 1; k <= 9; k++) step(1'b0, 3'd0, (k < 4) ? 8'h02 : 8'h00);
    step(1'b1, 3'd6, 8'h02);
    chk("overrun_set", 32'(o_overrun), 32'd1);
    repeat (11) step(1'b0, 3'd0, 8'h00);
    chk("ovr_result1", 32'(o_result_valid), 32'd1);
    chk("ovr_pcount1", 32'(o_pattern_count), 32'd7);
    chk("ovr_ccount1", 32'(o_correct_count), 32'd4);
    step(1'b1, 3'd4, 8'h00);
    chk("ovr_window2", 32'(o_window_active), 32'd1);
    for (int k = 0; k < 20; k++) step(1'b0, 3'd0, (k < 3) ? 8'h10 : 8'h00);
    chk("ovr_no_early_result", 32'(o_result_valid), 32'd0);
    step(1'b0, 3'd0, 8'h00);
    chk("ovr_result2", 32'(o_result_valid), 32'd1);
    chk("ovr_winner2", 32'(o_winner), 32'd4);
    chk("ovr_ccount2", 32'(o_correct_count), 32'd5);

    // Freeze mid-window: counts clear, teaching stops, pattern still scored.
    step(1'b1, 3'd2, 8'h00);
    repeat (9) step(1'b0, 3'd0, 8'h04);
    eoe_lvl = 1'b1;
    step(1'b0, 3'd0, 8'h04);
    chk("frz_pcount", 32'(o_pattern_count), 32'd0);
    chk("frz_ccount", 32'(o_correct_count), 32'd0);
    chk("frz_flag", 32'(o_frozen), 32'd1);
    chk("frz_teacher_slot", 32'(o_teacher_spike), 32'd0);
    repeat (10) step(1'b0, 3'd0, 8'h00);
    step(1'b0, 3'd0, 8'h00);
    chk("frz_result", 32'(o_result_valid), 32'd1);
    chk("frz_scored_pcount", 32'(o_pattern_count), 32'd1);
    chk("frz_winner", 32'(o_winner), 32'd2);

    // Reset at T+8 aborts the window; no result pulse follows.
    step(1'b1, 3'd5, 8'h00);
    repeat (7) step(1'b0, 3'd0, 8'h20);
    rst_lvl = 1'b0;
    step(1'b0, 3'd0, 8'h20);
    chk("rst_mid_frozen", 32'(o_frozen), 32'd0);
    chk("rst_mid_overrun", 32'(o_overrun), 32'd0);
    chk("rst_mid_window", 32'(o_window_active), 32'd0);
    chk("rst_mid_teacher", 32'(o_teacher_spike), 32'd0);
    rst_lvl = 1'b1;
    eoe_lvl = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 3'd0, 8'h00);
      if (o_result_valid === 1'b1) rv_seen++;
    end
    chk("rst_no_result", 32'(rv_seen), 32'd0);
    run_pattern(3'd5, {5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0});
    chk("post_rst_result", 32'(o_result_valid), 32'd1);
    chk("post_rst_winner", 32'(o_winner), 32'd5);
    chk("post_rst_pcount", 32'(o_pattern_count), 32'd1);

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 700; k++) begin
      step(($urandom % 12) == 0, 3'($urandom), 8'($urandom) & 8'($urandom));
    end
    repeat (25) step(1'b0, 3'd0, 8'h00);

    // Freeze on the same edge a result registers: result shown, not counted.
    step(1'b1, 3'd0, 8'h00);
    for (int k = 0; k < 20; k++) step(1'b0, 3'd0, (k < 2) ? 8'h01 : 8'h00);
    eoe_lvl = 1'b1;
    step(1'b0, 3'd0, 8'h00);
    chk("same_edge_result", 32'(o_result_valid), 32'd1);
    chk("same_edge_correct", 32'(o_correct), 32'd1);
    chk("same_edge_pcount", 32'(o_pattern_count), 32'd0);
    chk("same_edge_ccount", 32'(o_correct_count), 32'd0);
    chk("same_edge_frozen", 32'(o_frozen), 32'd1);
    repeat (3) step(1'b0, 3'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
